// File: rtl/shift_sat_pkg.sv
// Shared constants, widths and arithmetic helpers for the runtime shifter.
package shift_sat_pkg;

  localparam int ROUND_TRUNCATE = 0;
  localparam int ROUND_NEAREST  = 1;

  // Saturation is evaluated on a wide signed value so any lane width fits.
  localparam int SAT_W = 64;

  typedef struct packed {
    logic signed [SAT_W-1:0] value;
    logic                    clip_hi;
    logic                    clip_lo;
  } sat_t;

  // Headroom for a full left shift plus one sign bit.
  function automatic int ext_width(int din_w, int max_shift);
    return din_w + max_shift + 1;
  endfunction

  // Limit a requested shift to the legal +/-max_shift window.
  function automatic logic signed [31:0] clamp_shift(logic signed [31:0] s, int max_shift);
    if (s > max_shift) return max_shift;
    if (s < -max_shift) return -max_shift;
    return s;
  endfunction

  // Clamp to the representable range of the output word and report which side clipped.
  function automatic sat_t saturate(logic signed [SAT_W-1:0] v, int dout_w, bit is_signed);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_t r;
    if (is_signed) begin
      hi = (64'sd1 <<< (dout_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dout_w - 1));
    end else begin
      hi = (64'sd1 <<< dout_w) - 64'sd1;
      lo = '0;
    end
    r.value   = v;
    r.clip_hi = 1'b0;
    r.clip_lo = 1'b0;
    if (v > hi) begin
      r.value   = hi;
      r.clip_hi = 1'b1;
    end else if (v < lo) begin
      r.value   = lo;
      r.clip_lo = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_sat_lane.sv
// One channel of the shifter: stage 1 shifts/rounds, stage 2 saturates.
module shift_sat_lane
  import shift_sat_pkg::*;
#(
  parameter int DIN_WIDTH   = 16,
  parameter int DOUT_WIDTH  = 16,
  parameter int MAX_SHIFT   = 8,
  parameter int SHIFT_WIDTH = 5,
  parameter bit IS_SIGNED   = 1'b1,
  parameter int RMODE       = ROUND_TRUNCATE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [DIN_WIDTH-1:0]          din,
  input  logic signed [SHIFT_WIDTH-1:0] shift,
  output logic [DOUT_WIDTH-1:0]         dout,
  output logic [1:0]                    warning
);

  localparam int EXT = ext_width(DIN_WIDTH, MAX_SHIFT);

  logic                   sign_in;
  logic [SHIFT_WIDTH-1:0] mag;
  logic signed [EXT-1:0]  ext_val;
  logic signed [EXT-1:0]  rnd_val;
  logic signed [EXT-1:0]  shf_val;
  logic signed [EXT-1:0]  shf_p1;
  sat_t                   sat_res;
  logic [DOUT_WIDTH-1:0]  dout_p2;
  logic [1:0]             warn_p2;
  logic                   unused_hi;

  // Widen the sample, then shift left or round-and-shift right by |shift|.
  always_comb begin
    sign_in = IS_SIGNED ? din[DIN_WIDTH-1] : 1'b0;
    ext_val = {{(EXT-DIN_WIDTH){sign_in}}, din};
    mag     = shift[SHIFT_WIDTH-1] ? SHIFT_WIDTH'(-shift) : shift;
    rnd_val = ext_val;
    if (RMODE == ROUND_NEAREST && shift[SHIFT_WIDTH-1])
      rnd_val = ext_val + (EXT'(1) << (mag - SHIFT_WIDTH'(1)));
    if (shift == '0)
      shf_val = ext_val;
    else if (!shift[SHIFT_WIDTH-1])
      shf_val = ext_val <<< mag;
    else
      shf_val = rnd_val >>> mag;
  end

  // Stage 1 boundary: hold the shifted wide value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  shf_p1 <= '0;
    else if (en) shf_p1 <= shf_val;
  end

  // Clamp the wide value to the output word.
  always_comb begin
    sat_res = saturate(SAT_W'(shf_p1), DOUT_WIDTH, IS_SIGNED);
  end

  assign unused_hi = ^sat_res.value[SAT_W-1:DOUT_WIDTH];

  // Stage 2 boundary: register saturated sample and its clip flags together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_p2 <= '0;
      warn_p2 <= '0;
    end else if (en) begin
      dout_p2 <= sat_res.value[DOUT_WIDTH-1:0];
      warn_p2 <= {sat_res.clip_lo, sat_res.clip_hi};
    end
  end

  assign dout    = dout_p2;
  assign warning = warn_p2;

endmodule

// File: rtl/shift_sat_pipe.sv
// Multi-channel runtime shifter with saturation on a 2-stage valid/ready pipe.
module shift_sat_pipe
  import shift_sat_pkg::*;
#(
  parameter int    DIN_WIDTH   = 16,
  parameter int    DOUT_WIDTH  = 16,
  parameter int    N_CHANNELS  = 1,
  parameter string DATA_TYPE   = "signed",
  parameter int    MAX_SHIFT   = 8,
  parameter int    SHIFT_WIDTH = 5,
  parameter string ROUND_MODE  = "truncate"
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic signed [SHIFT_WIDTH-1:0]  shift_amt,
  input  logic                           shift_load,
  input  logic [N_CHANNELS*DIN_WIDTH-1:0] din,
  input  logic                           din_valid,
  output logic                           din_ready,
  output logic [N_CHANNELS*DOUT_WIDTH-1:0] dout,
  output logic                           dout_valid,
  input  logic                           dout_ready,
  output logic [2*N_CHANNELS-1:0]        warning,
  output logic [N_CHANNELS-1:0]          ovf_sticky,
  input  logic                           ovf_clear
);

  localparam bit IS_SIGNED = (DATA_TYPE == "signed");
  localparam int RMODE     = (ROUND_MODE == "nearest") ? ROUND_NEAREST : ROUND_TRUNCATE;

  logic signed [SHIFT_WIDTH-1:0] shift_q;
  logic                          en;
  logic                          vld_p1;
  logic                          vld_p2;
  logic                          out_xfer;
  logic [N_CHANNELS-1:0]         sticky_set;

  assign en        = !vld_p2 || dout_ready;
  assign din_ready = en;
  assign out_xfer  = vld_p2 && dout_ready;

  // Shift amount register; samples accepted from the next cycle use the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          shift_q <= '0;
    else if (shift_load) shift_q <= SHIFT_WIDTH'(clamp_shift(32'(shift_amt), MAX_SHIFT));
  end

  // Valid tokens advance with the datapath only when the pipe is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (en) begin
      vld_p1 <= din_valid;
      vld_p2 <= vld_p1;
    end
  end

  assign dout_valid = vld_p2;

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_lane
    shift_sat_lane #(
      .DIN_WIDTH  (DIN_WIDTH),
      .DOUT_WIDTH (DOUT_WIDTH),
      .MAX_SHIFT  (MAX_SHIFT),
      .SHIFT_WIDTH(SHIFT_WIDTH),
      .IS_SIGNED  (IS_SIGNED),
      .RMODE      (RMODE)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .din    (din[c*DIN_WIDTH +: DIN_WIDTH]),
      .shift  (shift_q),
      .dout   (dout[c*DOUT_WIDTH +: DOUT_WIDTH]),
      .warning(warning[2*c +: 2])
    );
  end

  // A channel flags overflow when a clipped sample actually leaves the block.
  always_comb begin
    sticky_set = '0;
    for (int c = 0; c < N_CHANNELS; c++)
      sticky_set[c] = out_xfer && (|warning[2*c +: 2]);
  end

  // Sticky overflow: a new event beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= '0;
    end else begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        if (sticky_set[c])  ovf_sticky[c] <= 1'b1;
        else if (ovf_clear) ovf_sticky[c] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_sat_pipe.sv
// Bench for shift_sat_pipe: two channels, truncate (A) and nearest (B) instances fed identically.
module tb_shift_sat_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic signed [5:0] shift_amt;
  logic              shift_load;
  logic [31:0]       din;
  logic              din_valid;
  logic              dout_ready;
  logic              ovf_clear;

  logic        din_ready_a, dout_valid_a, din_ready_b, dout_valid_b;
  logic [31:0] dout_a, dout_b;
  logic [3:0]  warning_a, warning_b;
  logic [1:0]  sticky_a, sticky_b;

  shift_sat_pipe #(
    .DIN_WIDTH(16), .DOUT_WIDTH(16), .N_CHANNELS(2), .DATA_TYPE("signed"),
    .MAX_SHIFT(8), .SHIFT_WIDTH(6), .ROUND_MODE("truncate")
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .shift_amt(shift_amt), .shift_load(shift_load),
    .din(din), .din_valid(din_valid), .din_ready(din_ready_a),
    .dout(dout_a), .dout_valid(dout_valid_a), .dout_ready(dout_ready),
    .warning(warning_a), .ovf_sticky(sticky_a), .ovf_clear(ovf_clear)
  );

  shift_sat_pipe #(
    .DIN_WIDTH(16), .DOUT_WIDTH(16), .N_CHANNELS(2), .DATA_TYPE("signed"),
    .MAX_SHIFT(8), .SHIFT_WIDTH(6), .ROUND_MODE("nearest")
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .shift_amt(shift_amt), .shift_load(shift_load),
    .din(din), .din_valid(din_valid), .din_ready(din_ready_b),
    .dout(dout_b), .dout_valid(dout_valid_b), .dout_ready(dout_ready),
    .warning(warning_b), .ovf_sticky(sticky_b), .ovf_clear(ovf_clear)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic longint m_shift(input int x, input int s, input bit nearest);
    longint d, n, q;
    if (s >= 0) return longint'(x) * (longint'(1) << s);
    d = longint'(1) << (-s);
    n = longint'(x) + (nearest ? d / 2 : 0);
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;   // floor division
    return q;
  endfunction

  function automatic int m_sat(input longint v, output int w);
    if (v > 32767)  begin w = 1; return 32767;  end
    if (v < -32768) begin w = 2; return -32768; end
    w = 0;
    return int'(v);
  endfunction

  function automatic int m_clamp(input int s);
    if (s > 8) return 8;
    if (s < -8) return -8;
    return s;
  endfunction

  typedef struct {
    int a0, a1, b0, b1;
    int wa0, wa1, wb0, wb1;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   e;
  int     out_log[$];
  int     n_out = 0;
  int     model_s = 0;
  bit     hold_pending = 0;
  logic [31:0] held_dout;
  logic [3:0]  held_warn;

  function automatic exp_t predict(input int x0, input int x1, input int s);
    exp_t r;
    int w;
    r.a0 = m_sat(m_shift(x0, s, 1'b0), w); r.wa0 = w;
    r.a1 = m_sat(m_shift(x1, s, 1'b0), w); r.wa1 = w;
    r.b0 = m_sat(m_shift(x0, s, 1'b1), w); r.wb0 = w;
    r.b1 = m_sat(m_shift(x1, s, 1'b1), w); r.wb1 = w;
    return r;
  endfunction

  // Compare process: runs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_s = 0;
      hold_pending = 0;
    end else begin
      if (hold_pending) begin
        chk("hold_valid", dout_valid_a, 1);
        chk("hold_dout", dout_a, held_dout);
        chk("hold_warn", warning_a, held_warn);
      end
      if (dout_valid_a && dout_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output got=%0d want=none", $signed(dout_a[15:0]));
        end else begin
          e = exp_q.pop_front();
          chk("a_ch0", $signed(dout_a[15:0]),  e.a0);
          chk("a_ch1", $signed(dout_a[31:16]), e.a1);
          chk("b_ch0", $signed(dout_b[15:0]),  e.b0);
          chk("b_ch1", $signed(dout_b[31:16]), e.b1);
          chk("a_warn0", warning_a[1:0], e.wa0);
          chk("a_warn1", warning_a[3:2], e.wa1);
          chk("b_warn0", warning_b[1:0], e.wb0);
          chk("b_warn1", warning_b[3:2], e.wb1);
          chk("b_valid", dout_valid_b, 1);
          out_log.push_back(int'($signed(dout_a[15:0])));
          n_out++;
        end
      end
      hold_pending = dout_valid_a && !dout_ready;
      held_dout = dout_a;
      held_warn = warning_a;
      if (din_valid && din_ready_a)
        exp_q.push_back(predict(int'($signed(din[15:0])), int'($signed(din[31:16])), model_s));
      if (shift_load) model_s = m_clamp(int'(shift_amt));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack(input int x);
    logic [15:0] lo;
    lo = 16'(x);
    return {~lo, lo};
  endfunction

  task automatic load(input int s);
    shift_amt = 6'(s);
    shift_load = 1'b1;
    tick();
    shift_load = 1'b0;
  endtask

  // Push one sample with dout_ready high; return channel-0 results seen on dout.
  task automatic single(input int x, output int ra, output int rb, output int wa);
    din = pack(x);
    din_valid = 1'b1;
    dout_ready = 1'b1;
    chk("single_din_ready", din_ready_a, 1);
    tick();
    din_valid = 1'b0;
    chk("lat1_valid", dout_valid_a, 0);
    tick();
    chk("lat2_valid", dout_valid_a, 1);
    ra = int'($signed(dout_a[15:0]));
    rb = int'($signed(dout_b[15:0]));
    wa = int'(warning_a[1:0]);
    tick();
  endtask

  int ra, rb, wa, n0, sent;
  bit acc;
  int bp_samples[6] = '{100, -200, 300, -400, 500, -600};

  initial begin
    rst_n = 1'b0; shift_amt = '0; shift_load = 1'b0; din = '0;
    din_valid = 1'b0; dout_ready = 1'b1; ovf_clear = 1'b0;

    // Reset state
    #23;
    chk("rst_dout_valid", dout_valid_a, 0);
    chk("rst_dout", dout_a, 0);
    chk("rst_warning", warning_a, 0);
    chk("rst_sticky", sticky_a, 0);
    chk("rst_din_ready", din_ready_a, 1);
    tick();
    rst_n = 1'b1;
    tick();

    // Model pins
    chk("pin_trunc_neg", m_shift(-13, -3, 1'b0), -2);
    chk("pin_near_neg", m_shift(-12, -3, 1'b1), -1);

    // Left shift in range and saturation
    load(2);
    single(4096, ra, rb, wa);
    chk("lsh_4096", ra, 16384);
    chk("lsh_4096_warn", wa, 0);
    single(8192, ra, rb, wa);
    chk("sat_hi", ra, 32767);
    chk("sat_hi_warn", wa, 1);
    single(-8193, ra, rb, wa);
    chk("sat_lo", ra, -32768);
    chk("sat_lo_warn", wa, 2);
    chk("sticky_set", sticky_a, 2'b11);
    tick();
    chk("sticky_hold", sticky_a, 2'b11);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    chk("sticky_clear", sticky_a, 0);

    // Clear held through a clipping transfer: set wins
    ovf_clear = 1'b1;
    single(8192, ra, rb, wa);
    chk("sticky_set_wins", sticky_a, 2'b11);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    chk("sticky_clear2", sticky_a, 0);

    // Rounding on right shifts
    load(-3);
    single(12, ra, rb, wa);
    chk("trunc_12", ra, 1);
    chk("near_12", rb, 2);
    single(-13, ra, rb, wa);
    chk("trunc_m13", ra, -2);
    chk("near_m13", rb, -2);
    single(-12, ra, rb, wa);
    chk("trunc_m12", ra, -2);
    chk("near_m12", rb, -1);

    // Backpressure: 6 back-to-back samples, dout_ready low for cycles 3-5
    load(1);
    n0 = n_out;
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      dout_ready = !(c >= 3 && c <= 5);
      din_valid = (sent < 6);
      din = pack(bp_samples[(sent < 6) ? sent : 0]);
      if (c == 4) begin
        chk("bp_din_ready_low", din_ready_a, 0);
        chk("bp_valid_held", dout_valid_a, 1);
      end
      @(negedge clk);
      acc = din_valid && din_ready_a;
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    din_valid = 1'b0;
    dout_ready = 1'b1;
    chk("bp_sent", sent, 6);
    chk("bp_received", n_out - n0, 6);

    // Shift request clamp
    load(20);
    single(1, ra, rb, wa);
    chk("clamp_pos", ra, 256);

    // Mid-stream shift change
    out_log.delete();
    din = pack(3); din_valid = 1'b1;
    tick();
    din = pack(5); shift_amt = -6'sd1; shift_load = 1'b1;
    tick();
    shift_load = 1'b0;
    din = pack(7);
    tick();
    din = pack(9);
    tick();
    din_valid = 1'b0;
    repeat (4) tick();
    chk("mid_count", out_log.size(), 4);
    if (out_log.size() == 4) begin
      chk("mid_0", out_log[0], 768);
      chk("mid_1", out_log[1], 1280);
      chk("mid_2", out_log[2], 3);
      chk("mid_3", out_log[3], 4);
    end

    // Reset with two samples in flight
    din = pack(11); din_valid = 1'b1;
    tick();
    din = pack(22);
    tick();
    din_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", dout_valid_a, 0);
    chk("midrst_dout", dout_a, 0);
    chk("midrst_warn", warning_a, 0);
    tick();
    tick();
    rst_n = 1'b1;
    n0 = n_out;
    repeat (5) tick();
    chk("no_stale_out", n_out - n0, 0);
    chk("no_stale_valid", dout_valid_a, 0);

    // Shift register returns to zero after reset
    single(1234, ra, rb, wa);
    chk("post_rst_pass", ra, 1234);

    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
